signed_or_unsigned_mul_iter: RTL and testbench

Parametrised, multi-cycle shift-add multiplier. Computes the 2n-bit product of two n-bit operands as signed or unsigned, selected per transaction. Each transaction enters through a valid/ready argument port and leaves through a valid/ready result port. It sits where a single-cycle n×n multiplier is too large or too slow: one adder of 2n bits, n iterations per product.

---
 rtl/signed_or_unsigned_mul_iter_pkg.sv | 41 ++++
 rtl/signed_or_unsigned_mul_iter_if.sv | 23 ++
 rtl/signed_or_unsigned_mul_iter_step.sv | 27 ++
 rtl/signed_or_unsigned_mul_iter.sv | 104 ++++++++++
 tb/tb_signed_or_unsigned_mul_iter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_or_unsigned_mul_iter_pkg.sv
// Shared types and the reference product for the iterative shift-add multiplier.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int REF_MAX_N = 32;

  // Full-width native product of the extended operands, truncated to 2n bits.
  function automatic logic [2*REF_MAX_N-1:0] mul_ref(
    input int                   n,
    input logic [REF_MAX_N-1:0] a,
    input logic [REF_MAX_N-1:0] b,
    input logic                 is_signed
  );
    logic [2*REF_MAX_N-1:0] ae;
    logic [2*REF_MAX_N-1:0] be;
    logic [2*REF_MAX_N-1:0] p;
    logic                   ext_a;
    logic                   ext_b;
    ext_a = is_signed & a[n-1];
    ext_b = is_signed & b[n-1];
    ae = '0;
    be = '0;
    for (int i = 0; i < REF_MAX_N; i++) begin
      ae[i] = (i < n) ? a[i] : ext_a;
      be[i] = (i < n) ? b[i] : ext_b;
    end
    ae[2*REF_MAX_N-1:REF_MAX_N] = {REF_MAX_N{ext_a}};
    be[2*REF_MAX_N-1:REF_MAX_N] = {REF_MAX_N{ext_b}};
    p = ae * be;
    for (int i = 0; i < 2*REF_MAX_N; i++) begin
      if (i >= 2*n) p[i] = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/signed_or_unsigned_mul_iter_if.sv
// Argument and result handshake bundle for the iterative multiplier.
interface signed_or_unsigned_mul_iter_if #(
  parameter int n = 8
);
  logic           arg_vld;
  logic           arg_rdy;
  logic [n-1:0]   a;
  logic [n-1:0]   b;
  logic           signed_mul;
  logic           res_vld;
  logic           res_rdy;
  logic [2*n-1:0] res;

  modport master (
    output arg_vld, a, b, signed_mul, res_rdy,
    input  arg_rdy, res_vld, res
  );

  modport slave (
    input  arg_vld, a, b, signed_mul, res_rdy,
    output arg_rdy, res_vld, res
  );
endinterface

// File: rtl/signed_or_unsigned_mul_iter_step.sv
// One shift-add iteration: conditionally add (or, for a signed MSB, subtract)
// the multiplicand shifted by the iteration index.
module shift_add_mul_step #(
  parameter int n  = 8,
  parameter int CW = 3
) (
  input  logic signed [2*n-1:0] acc,
  input  logic signed [2*n-1:0] mcand,
  input  logic                  mbit,
  input  logic        [CW-1:0]  idx,
  input  logic                  sub,
  output logic signed [2*n-1:0] acc_nxt
);

  logic signed [2*n-1:0] partial;

  always_comb begin
    partial = mcand << idx;
    if (!mbit)
      acc_nxt = acc;
    else if (sub)
      acc_nxt = acc - partial;
    else
      acc_nxt = acc + partial;
  end

endmodule

// File: rtl/signed_or_unsigned_mul_iter.sv
// Multi-cycle signed/unsigned n x n multiplier: one 2n-bit adder, n iterations
// per product, valid/ready on both the argument and result sides.
module signed_or_unsigned_mul_iter
  import mul_iter_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  signed_or_unsigned_mul_iter_if.slave  bus
);

  localparam int            CW   = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  mul_state_t state;
  mul_state_t state_nxt;

  logic        [n-1:0]   a_q;
  logic        [n-1:0]   b_q;
  logic                  signed_q;
  logic        [CW-1:0]  cnt;
  logic signed [2*n-1:0] acc;
  logic signed [2*n-1:0] acc_nxt;
  logic signed [2*n-1:0] mcand_ext;
  logic                  last_sub;
  logic                  accept;
  logic                  arg_rdy_c;
  logic                  res_vld_c;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // rst gates the argument handshake so reset always wins over an accept.
  always_comb begin
    state_nxt = state;
    arg_rdy_c = 1'b0;
    res_vld_c = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        arg_rdy_c = !rst;
        if (bus.arg_vld && !rst) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        res_vld_c = 1'b1;
        if (bus.res_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      signed_q <= bus.signed_mul;
    end
  end

  // The accumulator doubles as the result register, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign mcand_ext = signed_q ? {{n{a_q[n-1]}}, a_q} : {{n{1'b0}}, a_q};
  assign last_sub  = signed_q && (cnt == LAST);

  shift_add_mul_step #(
    .n  (n),
    .CW (CW)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand_ext),
    .mbit    (b_q[cnt]),
    .idx     (cnt),
    .sub     (last_sub),
    .acc_nxt (acc_nxt)
  );

  assign bus.arg_rdy = arg_rdy_c;
  assign bus.res_vld = res_vld_c;
  assign bus.res     = acc;

endmodule

// File: tb/tb_signed_or_unsigned_mul_iter.sv
// Scoreboard bench for the iterative multiplier at n=4 and n=8.
module tb_signed_or_unsigned_mul_iter;
  import mul_iter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_or_unsigned_mul_iter_if #(.n(4)) bus4 ();
  signed_or_unsigned_mul_iter_if #(.n(8)) bus8 ();

  signed_or_unsigned_mul_iter #(.n(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  signed_or_unsigned_mul_iter #(.n(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers only; every comparison lives in the test tasks.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s);
    bus4.a = a; bus4.b = b; bus4.signed_mul = s; bus4.arg_vld = 1'b1;
    for (int k = 0; k < 50 && !bus4.arg_rdy; k++) tick();
    tick();
    bus4.arg_vld = 1'b0;
    q4.push_back(8'(mul_ref(4, 32'(a), 32'(b), s)));
  endtask

  task automatic wait_vld4(output int lat);
    lat = 0;
    while (!bus4.res_vld && lat < 200) begin tick(); lat++; end
  endtask

  task automatic consume4(output logic [7:0] got, output logic [7:0] exp);
    got = bus4.res;
    exp = (q4.size() != 0) ? q4.pop_front() : 8'hxx;
    bus4.res_rdy = 1'b1;
    tick();
    bus4.res_rdy = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    bus8.a = a; bus8.b = b; bus8.signed_mul = s; bus8.arg_vld = 1'b1;
    for (int k = 0; k < 50 && !bus8.arg_rdy; k++) tick();
    tick();
    bus8.arg_vld = 1'b0;
    q8.push_back(16'(mul_ref(8, 32'(a), 32'(b), s)));
  endtask

  task automatic test_reset();
    bus4.arg_vld = 0; bus4.a = 0; bus4.b = 0; bus4.signed_mul = 0; bus4.res_rdy = 0;
    bus8.arg_vld = 0; bus8.a = 0; bus8.b = 0; bus8.signed_mul = 0; bus8.res_rdy = 0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (bus4.arg_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_arg_rdy: got %b want 0", bus4.arg_rdy); end
    n_cmp++; if (bus4.res_vld !== 1'b0) begin n_bad++; $display("FAIL rst_res_vld: got %b want 0", bus4.res_vld); end
    n_cmp++; if (bus4.res !== 8'h00) begin n_bad++; $display("FAIL rst_res: got %h want 00", bus4.res); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus4.arg_rdy !== 1'b1) begin n_bad++; $display("FAIL post_rst_arg_rdy: got %b want 1", bus4.arg_rdy); end
    n_cmp++; if (bus8.arg_rdy !== 1'b1) begin n_bad++; $display("FAIL post_rst_arg_rdy8: got %b want 1", bus8.arg_rdy); end
  endtask

  task automatic test_unsigned_max();
    int lat;
    logic [7:0] got, exp;
    send4(4'hF, 4'hF, 1'b0);
    wait_vld4(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL umax_latency: got %0d want 4", lat); end
    consume4(got, exp);
    n_cmp++; if (got !== 8'hE1) begin n_bad++; $display("FAIL umax_res: got %h want e1", got); end
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL umax_ref: got %h want %h", got, exp); end
    n_cmp++; if (bus4.res_vld !== 1'b0) begin n_bad++; $display("FAIL umax_vld_drop: got %b want 0", bus4.res_vld); end
    n_cmp++; if (bus4.arg_rdy !== 1'b1) begin n_bad++; $display("FAIL umax_rdy_back: got %b want 1", bus4.arg_rdy); end
  endtask

  task automatic test_signed_corners();
    logic [3:0] ta[3] = '{4'h8, 4'h8, 4'h0};
    logic [3:0] tb[3] = '{4'h8, 4'h7, 4'hF};
    logic [7:0] tr[3] = '{8'h40, 8'hC8, 8'h00};
    int lat;
    logic [7:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      send4(ta[i], tb[i], 1'b1);
      wait_vld4(lat);
      consume4(got, exp);
      n_cmp++; if (got !== tr[i]) begin n_bad++; $display("FAIL signed_corner%0d: got %h want %h", i, got, tr[i]); end
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL signed_corner%0d_ref: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_mode_select();
    logic [7:0] want[2] = '{8'h1E, 8'hFE};
    int lat;
    logic [7:0] got, exp;
    for (int pert = 0; pert < 2; pert++) begin
      for (int s = 0; s < 2; s++) begin
        send4(4'hF, 4'h2, s[0]);
        if (pert == 1) begin
          bus4.a = 4'h3;
          bus4.signed_mul = ~s[0];
        end
        wait_vld4(lat);
        consume4(got, exp);
        n_cmp++; if (got !== want[s]) begin n_bad++; $display("FAIL mode_sel s=%0d pert=%0d: got %h want %h", s, pert, got, want[s]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] r0, got, exp;
    send4(4'h6, 4'hB, 1'b1);
    wait_vld4(lat);
    r0 = bus4.res;
    bus4.a = 4'h2; bus4.b = 4'h7; bus4.signed_mul = 1'b0; bus4.arg_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus4.res !== r0) begin n_bad++; $display("FAIL bp_res_stable c%0d: got %h want %h", k, bus4.res, r0); end
      n_cmp++; if (bus4.res_vld !== 1'b1) begin n_bad++; $display("FAIL bp_res_vld c%0d: got %b want 1", k, bus4.res_vld); end
      n_cmp++; if (bus4.arg_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_arg_rdy c%0d: got %b want 0", k, bus4.arg_rdy); end
      tick();
    end
    consume4(got, exp);
    n_cmp++; if (got !== 8'hE2) begin n_bad++; $display("FAIL bp_first_res: got %h want e2", got); end
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL bp_first_ref: got %h want %h", got, exp); end
    n_cmp++; if (bus4.arg_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_after_consume: got %b want 1", bus4.arg_rdy); end
    tick();
    bus4.arg_vld = 1'b0;
    q4.push_back(8'(mul_ref(4, 32'(4'h2), 32'(4'h7), 1'b0)));
    wait_vld4(lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp_second_latency: got %0d want 4", lat); end
    consume4(got, exp);
    n_cmp++; if (got !== 8'h0E) begin n_bad++; $display("FAIL bp_second_res: got %h want 0e", got); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] got, exp;
    send4(4'h7, 4'h7, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    q4.delete();
    n_cmp++; if (bus4.res_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_res_vld: got %b want 0", bus4.res_vld); end
    n_cmp++; if (bus4.res !== 8'h00) begin n_bad++; $display("FAIL rmid_res: got %h want 00", bus4.res); end
    n_cmp++; if (bus4.arg_rdy !== 1'b1) begin n_bad++; $display("FAIL rmid_arg_rdy: got %b want 1", bus4.arg_rdy); end
    send4(4'h3, 4'h5, 1'b0);
    wait_vld4(lat);
    consume4(got, exp);
    n_cmp++; if (got !== 8'h0F) begin n_bad++; $display("FAIL rmid_next_res: got %h want 0f", got); end
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [7:0] got, exp;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          send4(a[3:0], b[3:0], s[0]);
          wait_vld4(lat);
          n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL exh_latency %0d*%0d s=%0d: got %0d want 4", a, b, s, lat); end
          for (int k = 0, hold = $urandom_range(0, 3); k < hold; k++) tick();
          consume4(got, exp);
          n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL exh %0d*%0d s=%0d: got %h want %h", a, b, s, got, exp); end
        end
      end
    end
  endtask

  task automatic test_random8();
    int lat;
    logic [15:0] got, exp;
    logic [7:0] a, b;
    logic s;
    for (int i = 0; i < 2002; i++) begin
      if (i == 0) begin a = 8'h80; b = 8'h80; s = 1'b1; end
      else if (i == 1) begin a = 8'hFF; b = 8'hFF; s = 1'b0; end
      else begin a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); end
      send8(a, b, s);
      lat = 0;
      while (!bus8.res_vld && lat < 200) begin tick(); lat++; end
      n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL r8_latency %h*%h s=%b: got %0d want 8", a, b, s, lat); end
      for (int k = 0, hold = $urandom_range(0, 2); k < hold; k++) tick();
      got = bus8.res;
      exp = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
      bus8.res_rdy = 1'b1;
      tick();
      bus8.res_rdy = 1'b0;
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL r8 %h*%h s=%b: got %h want %h", a, b, s, got, exp); end
      if (i == 0) begin
        n_cmp++; if (got !== 16'h4000) begin n_bad++; $display("FAIL r8_smin: got %h want 4000", got); end
      end
      if (i == 1) begin
        n_cmp++; if (got !== 16'hFE01) begin n_bad++; $display("FAIL r8_umax: got %h want fe01", got); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_mode_select();
    test_backpressure();
    test_reset_mid();
    test_exhaustive4();
    test_random8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
